// File: rtl/minic_pmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// minic_pmem_arb_pkg
// Shared types and constants for the mini-NIC packet memory arbiter.
//   t_wb_state        : host Wishbone port FSM state (WB_IDLE, WB_ACK)
//   c_pmem_data_width : packet memory data width
//   c_fair_cnt_width  : width of the optional fairness counter
// -----------------------------------------------------------------------------
package minic_pmem_arb_pkg;

   localparam int c_pmem_data_width = 32;
   localparam int c_fair_cnt_width  = 8;

   typedef enum logic [0:0] {
      WB_IDLE = 1'b0,
      WB_ACK  = 1'b1
   } t_wb_state;

   // Even parity over a data word, for use by checkers and wrappers
   function automatic logic pmem_parity(input logic [c_pmem_data_width-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/minic_pmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// minic_pmem_arbiter_if
// Host Wishbone classic slave bus into the packet memory arbiter.
//   cyc, stb, we : Wishbone cycle / strobe / write enable   (master -> slave)
//   addr         : word address, g_addr_width bits          (master -> slave)
//   wdata        : write data                               (master -> slave)
//   rdata        : read data, valid while ack is set        (slave -> master)
//   ack          : one-cycle acknowledge                    (slave -> master)
// -----------------------------------------------------------------------------
interface minic_pmem_arbiter_if #(
   parameter int g_addr_width = 14
);
   import minic_pmem_arb_pkg::*;

   logic                          cyc;
   logic                          stb;
   logic                          we;
   logic [g_addr_width-1:0]       addr;
   logic [c_pmem_data_width-1:0]  wdata;
   logic [c_pmem_data_width-1:0]  rdata;
   logic                          ack;

   modport master (
      output cyc, stb, we, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  cyc, stb, we, addr, wdata,
      output rdata, ack
   );

endinterface

// File: rtl/minic_pmem_arbiter_fair_cnt.sv
// -----------------------------------------------------------------------------
// minic_pmem_fair_cnt
// Saturating count of mini-NIC grants taken while a host access waits.
// When the count reaches g_max_minic_burst the override flag hands the next
// arbitration to the host.
//   clk_sys_i, rst_i : clock, synchronous active-high reset
//   host_pending     : host request waiting in WB_IDLE
//   minic_gnt        : mini-NIC granted this cycle
//   host_gnt         : host issued this cycle
//   override         : host must win this cycle
// Only instantiated when MINIC_PMEM_ARB_FAIRNESS_EN is defined.
// -----------------------------------------------------------------------------
module minic_pmem_fair_cnt
   import minic_pmem_arb_pkg::*;
#(
   parameter int g_max_minic_burst = 8
) (
   input  logic clk_sys_i,
   input  logic rst_i,
   input  logic host_pending,
   input  logic minic_gnt,
   input  logic host_gnt,
   output logic override
);

   localparam logic [c_fair_cnt_width-1:0] c_max_burst = c_fair_cnt_width'(g_max_minic_burst);
   localparam logic [c_fair_cnt_width-1:0] c_cnt_sat   = {c_fair_cnt_width{1'b1}};

   logic [c_fair_cnt_width-1:0] cnt;

   // Count mini-NIC wins against a waiting host; any host grant or idle host restarts the count
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         cnt <= {c_fair_cnt_width{1'b0}};
      end else if (host_gnt || !host_pending) begin
         cnt <= {c_fair_cnt_width{1'b0}};
      end else if (minic_gnt && (cnt != c_cnt_sat)) begin
         cnt <= cnt + {{(c_fair_cnt_width-1){1'b0}}, 1'b1};
      end else begin
         cnt <= cnt;
      end
   end

   // Gated with host_pending so a host that vanished cannot block the mini-NIC
   assign override = host_pending && (cnt == c_max_burst);

endmodule

// File: rtl/minic_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// minic_pmem_arbiter
// Shares the single-port mini-NIC packet memory between the mini-NIC DMA port
// and a host Wishbone slave port; one access per cycle, mini-NIC priority.
// Optional feature macro: MINIC_PMEM_ARB_FAIRNESS_EN (bounds host starvation
// to g_max_minic_burst+1 cycles).
// Ports:
//   clk_sys_i, rst_i        : clock, synchronous active-high reset
//   minic_req/we/addr/data_i: mini-NIC request
//   minic_gnt_o             : mini-NIC access issued this cycle (comb.)
//   minic_rvalid_o          : read data valid, one cycle after a read grant
//   minic_data_o            : read data (memory output passed through)
//   wb                      : host Wishbone slave (minic_pmem_arbiter_if)
//   mem_en/we/addr/data_o   : packet memory request (comb. mux of winner)
//   mem_data_i              : packet memory read data, 1-cycle latency
// -----------------------------------------------------------------------------
module minic_pmem_arbiter
   import minic_pmem_arb_pkg::*;
#(
   parameter int g_addr_width      = 14,
   parameter int g_max_minic_burst = 8
) (
   input  logic                          clk_sys_i,
   input  logic                          rst_i,

   input  logic                          minic_req_i,
   input  logic                          minic_we_i,
   input  logic [g_addr_width-1:0]       minic_addr_i,
   input  logic [c_pmem_data_width-1:0]  minic_data_i,
   output logic                          minic_gnt_o,
   output logic                          minic_rvalid_o,
   output logic [c_pmem_data_width-1:0]  minic_data_o,

   minic_pmem_arbiter_if.slave           wb,

   output logic                          mem_en_o,
   output logic                          mem_we_o,
   output logic [g_addr_width-1:0]       mem_addr_o,
   output logic [c_pmem_data_width-1:0]  mem_data_o,
   input  logic [c_pmem_data_width-1:0]  mem_data_i
);

   if ((g_max_minic_burst < 1) || (g_max_minic_burst > 255)) begin : g_bad_burst
      $error("g_max_minic_burst out of range 1..255");
   end

   t_wb_state wb_state;
   logic      wb_ack;
   logic      minic_rvalid;
   logic      host_pending;
   logic      fair_override;
   logic      minic_win;
   logic      host_win;

   // No new host issue while in WB_ACK, so a strobe held through ack is not re-serviced
   assign host_pending = wb.cyc && wb.stb && (wb_state == WB_IDLE);

`ifdef MINIC_PMEM_ARB_FAIRNESS_EN
   minic_pmem_fair_cnt #(
      .g_max_minic_burst (g_max_minic_burst)
   ) u_fair_cnt (
      .clk_sys_i    (clk_sys_i),
      .rst_i        (rst_i),
      .host_pending (host_pending),
      .minic_gnt    (minic_win),
      .host_gnt     (host_win),
      .override     (fair_override)
   );
`else
   assign fair_override = 1'b0;
`endif

   assign minic_win = minic_req_i && !fair_override;
   assign host_win  = !minic_win && host_pending;

   // Memory request mux: the winning requester drives the single port
   always_comb begin
      mem_en_o   = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = {g_addr_width{1'b0}};
      mem_data_o = {c_pmem_data_width{1'b0}};
      if (minic_win) begin
         mem_en_o   = 1'b1;
         mem_we_o   = minic_we_i;
         mem_addr_o = minic_addr_i;
         mem_data_o = minic_data_i;
      end else if (host_win) begin
         mem_en_o   = 1'b1;
         mem_we_o   = wb.we;
         mem_addr_o = wb.addr;
         mem_data_o = wb.wdata;
      end else begin
         mem_en_o   = 1'b0;
         mem_we_o   = 1'b0;
         mem_addr_o = {g_addr_width{1'b0}};
         mem_data_o = {c_pmem_data_width{1'b0}};
      end
   end

   // Host FSM with registered ack; ack lands in the cycle the read data returns
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         wb_state <= WB_IDLE;
         wb_ack   <= 1'b0;
      end else begin
         case (wb_state)
            WB_IDLE: begin
               if (host_win) begin
                  wb_state <= WB_ACK;
                  wb_ack   <= 1'b1;
               end else begin
                  wb_state <= WB_IDLE;
                  wb_ack   <= 1'b0;
               end
            end
            WB_ACK: begin
               wb_state <= WB_IDLE;
               wb_ack   <= 1'b0;
            end
            default: begin
               wb_state <= WB_IDLE;
               wb_ack   <= 1'b0;
            end
         endcase
      end
   end

   // Mini-NIC read valid follows a granted read by one cycle
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         minic_rvalid <= 1'b0;
      end else begin
         minic_rvalid <= minic_win && !minic_we_i;
      end
   end

   assign minic_gnt_o    = minic_win;
   assign minic_rvalid_o = minic_rvalid;
   assign minic_data_o   = mem_data_i;
   assign wb.ack         = wb_ack;
   assign wb.rdata       = mem_data_i;

endmodule

// File: tb/tb_minic_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_minic_pmem_arbiter
// Directed self-checking bench for minic_pmem_arbiter with a behavioural
// single-port memory (1-cycle read latency). Inputs change on the falling
// edge; combinational outputs are sampled 1 time unit later, registered
// outputs at the following falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_minic_pmem_arbiter;
   localparam int AW = 14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        minic_req = 1'b0;
   logic        minic_we = 1'b0;
   logic [AW-1:0] minic_addr = '0;
   logic [31:0] minic_wdata = 32'h0;
   logic        minic_gnt;
   logic        minic_rvalid;
   logic [31:0] minic_rdata;
   logic        mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   logic [31:0] mem [0:(1<<AW)-1];
   int          n_tests = 0;
   int          n_fail = 0;
   int          n_mem_acc = 0;
   int          n_mem_wr = 0;
   int          n_acks = 0;

   minic_pmem_arbiter_if #(.g_addr_width(AW)) wb_bus ();

   minic_pmem_arbiter #(.g_addr_width(AW), .g_max_minic_burst(4)) dut (
      .clk_sys_i      (clk),
      .rst_i          (rst),
      .minic_req_i    (minic_req),
      .minic_we_i     (minic_we),
      .minic_addr_i   (minic_addr),
      .minic_data_i   (minic_wdata),
      .minic_gnt_o    (minic_gnt),
      .minic_rvalid_o (minic_rvalid),
      .minic_data_o   (minic_rdata),
      .wb             (wb_bus.slave),
      .mem_en_o       (mem_en),
      .mem_we_o       (mem_we),
      .mem_addr_o     (mem_addr),
      .mem_data_o     (mem_wdata),
      .mem_data_i     (mem_rdata)
   );

   always #5 clk = ~clk;

   // behavioural single-port memory plus access/ack counters
   always @(posedge clk) begin
      if (mem_en) begin
         n_mem_acc <= n_mem_acc + 1;
         if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            n_mem_wr <= n_mem_wr + 1;
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
      if (wb_bus.ack) n_acks <= n_acks + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic host_idle();
      wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
      wb_bus.addr = '0;  wb_bus.wdata = 32'h0;
   endtask

   task automatic host_req(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
      wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = we;
      wb_bus.addr = a;   wb_bus.wdata = d;
   endtask

   int acc0, wr0, ack0;

   initial begin
      host_idle();
      mem[16] = 32'hDEADBEEF;
      mem[1]  = 32'hA5A50001;
      mem[32] = 32'h0BAD_F00D;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_ack", {31'd0, wb_bus.ack}, 32'd0);
      check_val("rst_rvalid", {31'd0, minic_rvalid}, 32'd0);
      check_val("rst_gnt", {31'd0, minic_gnt}, 32'd0);
      check_val("rst_mem_en", {31'd0, mem_en}, 32'd0);

      // host-only read of 0x0010
      @(negedge clk);
      acc0 = n_mem_acc;
      host_req(1'b0, 14'h0010, 32'h0);
      #1;
      check_val("h_rd_en", {31'd0, mem_en}, 32'd1);
      check_val("h_rd_we", {31'd0, mem_we}, 32'd0);
      check_val("h_rd_addr", {18'd0, mem_addr}, 32'h10);
      @(negedge clk);
      check_val("h_rd_ack", {31'd0, wb_bus.ack}, 32'd1);
      check_val("h_rd_data", wb_bus.rdata, 32'hDEADBEEF);
      check_val("h_rd_no_reissue", {31'd0, mem_en}, 32'd0);
      host_idle();
      @(negedge clk);
      check_val("h_rd_ack_drop", {31'd0, wb_bus.ack}, 32'd0);
      check_val("h_rd_single_acc", n_mem_acc - acc0, 32'd1);

      // mini-NIC write then read back
      minic_req = 1'b1; minic_we = 1'b1; minic_addr = 14'h0100; minic_wdata = 32'h12345678;
      #1;
      check_val("m_wr_gnt", {31'd0, minic_gnt}, 32'd1);
      check_val("m_wr_we", {31'd0, mem_we}, 32'd1);
      @(negedge clk);
      minic_we = 1'b0;
      #1;
      check_val("m_rd_gnt", {31'd0, minic_gnt}, 32'd1);
      check_val("m_wr_no_rvalid", {31'd0, minic_rvalid}, 32'd0);
      @(negedge clk);
      minic_req = 1'b0;
      check_val("m_rd_rvalid", {31'd0, minic_rvalid}, 32'd1);
      check_val("m_rd_data", minic_rdata, 32'h12345678);

      // simultaneous mini-NIC read 0x0001 and host write 0x0002
      @(negedge clk);
      minic_req = 1'b1; minic_we = 1'b0; minic_addr = 14'h0001;
      host_req(1'b1, 14'h0002, 32'hCAFEF00D);
      #1;
      check_val("sim_m_gnt", {31'd0, minic_gnt}, 32'd1);
      check_val("sim_m_addr", {18'd0, mem_addr}, 32'h1);
      @(negedge clk);
      minic_req = 1'b0;
      #1;
      check_val("sim_m_rvalid", {31'd0, minic_rvalid}, 32'd1);
      check_val("sim_m_data", minic_rdata, 32'hA5A50001);
      check_val("sim_h_issue_en", {31'd0, mem_en}, 32'd1);
      check_val("sim_h_issue_we", {31'd0, mem_we}, 32'd1);
      check_val("sim_h_issue_addr", {18'd0, mem_addr}, 32'h2);
      check_val("sim_h_no_ack_yet", {31'd0, wb_bus.ack}, 32'd0);
      @(negedge clk);
      check_val("sim_h_ack", {31'd0, wb_bus.ack}, 32'd1);
      check_val("sim_h_mem", mem[2], 32'hCAFEF00D);
      host_idle();

      // host write with stb held through ack: one write, one ack
      @(negedge clk);
      wr0 = n_mem_wr; ack0 = n_acks;
      host_req(1'b1, 14'h0003, 32'h11112222);
      @(negedge clk);
      check_val("hold_ack", {31'd0, wb_bus.ack}, 32'd1);
      check_val("hold_no_access", {31'd0, mem_en}, 32'd0);
      @(negedge clk);
      host_idle();
      @(negedge clk);
      check_val("hold_one_write", n_mem_wr - wr0, 32'd1);
      check_val("hold_one_ack", n_acks - ack0, 32'd1);
      check_val("hold_mem", mem[3], 32'h11112222);

      // reset asserted in the cycle a host access issues
      @(negedge clk);
      host_req(1'b0, 14'h0010, 32'h0);
      rst = 1'b1;
      #1;
      check_val("rst_mid_issue", {31'd0, mem_en}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      check_val("rst_mid_no_ack", {31'd0, wb_bus.ack}, 32'd0);
      #1;
      check_val("rst_mid_reissue", {31'd0, mem_en}, 32'd1);
      @(negedge clk);
      check_val("rst_mid_ack", {31'd0, wb_bus.ack}, 32'd1);
      check_val("rst_mid_data", wb_bus.rdata, 32'hDEADBEEF);
      host_idle();
      @(negedge clk);

`ifdef MINIC_PMEM_ARB_FAIRNESS_EN
      // fairness, burst 4: two rounds prove the counter restarts from zero
      for (int r = 0; r < 2; r++) begin
         minic_req = 1'b1; minic_we = 1'b0; minic_addr = 14'h0001;
         host_req(1'b0, 14'h0020, 32'h0);
         for (int i = 0; i < 4; i++) begin
            #1;
            check_val("fair_m_gnt", {31'd0, minic_gnt}, 32'd1);
            @(negedge clk);
         end
         #1;
         check_val("fair_override_gnt", {31'd0, minic_gnt}, 32'd0);
         check_val("fair_h_addr", {18'd0, mem_addr}, 32'h20);
         @(negedge clk);
         check_val("fair_h_ack", {31'd0, wb_bus.ack}, 32'd1);
         check_val("fair_h_data", wb_bus.rdata, 32'h0BADF00D);
         host_idle();
         minic_req = 1'b0;
         @(negedge clk);
      end
`else
      // strict priority: a continuously requesting mini-NIC starves the host
      minic_req = 1'b1; minic_we = 1'b0; minic_addr = 14'h0001;
      host_req(1'b0, 14'h0020, 32'h0);
      for (int i = 0; i < 6; i++) begin
         #1;
         check_val("strict_m_gnt", {31'd0, minic_gnt}, 32'd1);
         check_val("strict_no_ack", {31'd0, wb_bus.ack}, 32'd0);
         @(negedge clk);
      end
      minic_req = 1'b0;
      #1;
      check_val("strict_h_issue", {18'd0, mem_addr}, 32'h20);
      @(negedge clk);
      check_val("strict_h_ack", {31'd0, wb_bus.ack}, 32'd1);
      check_val("strict_h_data", wb_bus.rdata, 32'h0BADF00D);
      host_idle();
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
